// File: rtl/result_frame_tx_pkg.sv
// Shared definitions for the result-frame transmitter: frame geometry,
// sync constants, FSM state encoding and the checksum fold helper.
package result_frame_tx_pkg;

    localparam int         NUM_SCORES_DEF = 10;
    localparam int         SCORE_BYTES    = 40;
    localparam int         FRAME_LEN      = 44;
    localparam logic [7:0] SYNC0_DEF      = 8'hA5;
    localparam logic [7:0] SYNC1_DEF      = 8'h5A;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_REQ   = 4'd1,
        ST_LOAD  = 4'd2,
        ST_FETCH = 4'd3,
        ST_LATCH = 4'd4,
        ST_SEND  = 4'd5,
        ST_GUARD = 4'd6,
        ST_WAIT  = 4'd7,
        ST_DONE  = 4'd8
    } state_t;

    // Running XOR checksum over payload bytes.
    function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/result_frame_tx_if.sv
// Shared TX path (request/grant, byte, strobe, busy) plus the scores_ram
// read port used by the result-frame transmitter.
interface result_frame_tx_if;
    logic       tx_req;
    logic       tx_gnt;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_busy;
    logic [5:0] scores_addr;
    logic [7:0] scores_data;

    modport master (
        output tx_req, tx_data, tx_send, scores_addr,
        input  tx_gnt, tx_busy, scores_data
    );

    modport slave (
        input  tx_req, tx_data, tx_send, scores_addr,
        output tx_gnt, tx_busy, scores_data
    );
endinterface

// File: rtl/result_frame_tx.sv
// Streams SYNC0, SYNC1, digit, all score bytes and an XOR checksum out
// through the shared uart_tx whenever an inference completes.
module result_frame_tx
    import result_frame_tx_pkg::*;
#(
    parameter logic [7:0] SYNC0      = SYNC0_DEF,
    parameter logic [7:0] SYNC1      = SYNC1_DEF,
    parameter int         NUM_SCORES = NUM_SCORES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   start,
    input  logic [3:0]             predicted_digit,
    result_frame_tx_if.master      tx,
    output logic                   busy,
    output logic                   overrun,
    output logic [7:0]             frame_count
);

    // Index of the checksum byte, i.e. the last byte of the frame.
    localparam int         LAST_IDX = 4 * NUM_SCORES + 3;
    localparam logic [5:0] LAST     = LAST_IDX[5:0];

    state_t     state;
    logic [5:0] idx;
    logic [3:0] digit;
    logic [7:0] csum;

    // Frame sequencer: byte-source mux, RAM fetch, UART handshake and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            idx            <= 6'd0;
            digit          <= 4'h0;
            csum           <= 8'h00;
            tx.tx_req      <= 1'b0;
            tx.tx_data     <= 8'h00;
            tx.tx_send     <= 1'b0;
            tx.scores_addr <= 6'd0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
            frame_count    <= 8'd0;
        end else begin
            tx.tx_send <= 1'b0;
            // A start that arrives while a frame is running is lost; flag it.
            if (start && busy) begin
                overrun <= 1'b1;
            end else begin
                overrun <= overrun;
            end
            case (state)
                ST_IDLE: begin
                    if (start && enable) begin
                        digit     <= predicted_digit;
                        csum      <= 8'h00;
                        idx       <= 6'd0;
                        tx.tx_req <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_REQ;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (tx.tx_gnt) begin
                        state <= ST_LOAD;
                    end else begin
                        state <= ST_REQ;
                    end
                end
                ST_LOAD: begin
                    // Without the grant, park here between bytes.
                    if (tx.tx_gnt) begin
                        case (idx)
                            6'd0: begin
                                tx.tx_data <= SYNC0;
                                state      <= ST_SEND;
                            end
                            6'd1: begin
                                tx.tx_data <= SYNC1;
                                state      <= ST_SEND;
                            end
                            6'd2: begin
                                tx.tx_data <= {4'h0, digit};
                                csum       <= csum_fold(csum, {4'h0, digit});
                                state      <= ST_SEND;
                            end
                            LAST: begin
                                tx.tx_data <= csum;
                                state      <= ST_SEND;
                            end
                            default: begin
                                tx.scores_addr <= idx - 6'd3;
                                state          <= ST_FETCH;
                            end
                        endcase
                    end else begin
                        state <= ST_LOAD;
                    end
                end
                ST_FETCH: begin
                    state <= ST_LATCH;
                end
                ST_LATCH: begin
                    tx.tx_data <= tx.scores_data;
                    csum       <= csum_fold(csum, tx.scores_data);
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    if (!tx.tx_busy && tx.tx_gnt) begin
                        tx.tx_send <= 1'b1;
                        state      <= ST_GUARD;
                    end else begin
                        state <= ST_SEND;
                    end
                end
                ST_GUARD: begin
                    // uart_tx raises busy one cycle after the strobe.
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!tx.tx_busy) begin
                        if (idx == LAST) begin
                            state <= ST_DONE;
                        end else begin
                            idx   <= idx + 6'd1;
                            state <= ST_LOAD;
                        end
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    tx.tx_req   <= 1'b0;
                    busy        <= 1'b0;
                    frame_count <= frame_count + 8'd1;
                    state       <= ST_IDLE;
                end
                default: begin
                    tx.tx_req <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_frame_tx.sv
// Directed bench for result_frame_tx with a simple uart_tx and scores_ram model.
module tb_result_frame_tx;
    import result_frame_tx_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       start = 1'b0;
    logic [3:0] predicted_digit = 4'h0;
    logic       busy;
    logic       overrun;
    logic [7:0] frame_count;

    result_frame_tx_if bus();

    result_frame_tx dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .start           (start),
        .predicted_digit (predicted_digit),
        .tx              (bus.master),
        .busy            (busy),
        .overrun         (overrun),
        .frame_count     (frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [64];
    logic [7:0] rx [$];
    int         sends = 0;
    int         ungranted = 0;
    int         busy_cnt = 0;
    logic [7:0] exp_b [44];

    // scores_ram: one-cycle registered read.
    always @(posedge clk) begin
        bus.scores_data <= ram[bus.scores_addr];
    end

    // uart_tx model: busy rises the cycle after a strobe and lasts 20 cycles.
    always @(posedge clk) begin
        if (bus.tx_send) begin
            rx.push_back(bus.tx_data);
            sends <= sends + 1;
            if (!bus.tx_gnt) ungranted <= ungranted + 1;
            busy_cnt    <= 20;
            bus.tx_busy <= 1'b1;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy_cnt    <= 0;
            bus.tx_busy <= 1'b0;
        end
    end

    // Reference frame from the bench's own RAM image.
    task automatic build_exp(input logic [3:0] d);
        logic [7:0] cs;
        exp_b[0] = 8'hA5;
        exp_b[1] = 8'h5A;
        exp_b[2] = {4'h0, d};
        cs = {4'h0, d};
        for (int i = 0; i < 40; i++) begin
            exp_b[3 + i] = ram[i];
            cs = cs ^ ram[i];
        end
        exp_b[43] = cs;
    endtask

    task automatic load_ramp();
        for (int k = 0; k < 10; k++) begin
            ram[4*k]   = 8'(k);
            ram[4*k+1] = 8'(k);
            ram[4*k+2] = 8'h00;
            ram[4*k+3] = 8'h00;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(output bit to);
        to = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (!busy) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_bytes(input int n, output bit to);
        to = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (rx.size() >= n) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.tx_req !== 1'b0) begin errors++; $display("FAIL reset_tx_req got %b want 0", bus.tx_req); end
        checks++; if (bus.tx_send !== 1'b0) begin errors++; $display("FAIL reset_tx_send got %b want 0", bus.tx_send); end
        checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
        checks++; if (bus.scores_addr !== 6'd0) begin errors++; $display("FAIL reset_scores_addr got %h want 00", bus.scores_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frame();
        bit to;
        load_ramp();
        build_exp(4'd7);
        predicted_digit = 4'd7;
        enable = 1'b1;
        bus.tx_gnt = 1'b1;
        rx.delete();
        pulse_start();
        checks++; if (bus.tx_req !== 1'b1) begin errors++; $display("FAIL frame_req_latency got %b want 1", bus.tx_req); end
        repeat (2) @(negedge clk);
        checks++; if (bus.tx_send !== 1'b0) begin errors++; $display("FAIL frame_send_early got %b want 0", bus.tx_send); end
        @(negedge clk);
        checks++; if (bus.tx_send !== 1'b1 || bus.tx_data !== 8'hA5) begin errors++; $display("FAIL frame_first_send got send=%b data=%h want send=1 data=a5", bus.tx_send, bus.tx_data); end
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL frame_timeout got busy=%b want 0", busy); end
        checks++; if (rx.size() != 44) begin errors++; $display("FAIL frame_len got %0d want 44", rx.size()); end
        if (rx.size() == 44) begin
            for (int i = 0; i < 44; i++) begin
                checks++; if (rx[i] !== exp_b[i]) begin errors++; $display("FAIL frame_byte%0d got %h want %h", i, rx[i], exp_b[i]); end
            end
            checks++; if (rx[7] !== 8'h01 || rx[8] !== 8'h01) begin errors++; $display("FAIL frame_score1 got %h %h want 01 01", rx[7], rx[8]); end
            checks++; if (rx[43] !== 8'h07) begin errors++; $display("FAIL frame_checksum got %h want 07", rx[43]); end
        end
        checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL frame_count1 got %0d want 1", frame_count); end
    endtask

    task automatic test_deadbeef();
        bit to;
        load_ramp();
        ram[12] = 8'hEF; ram[13] = 8'hBE; ram[14] = 8'hAD; ram[15] = 8'hDE;
        predicted_digit = 4'd7;
        rx.delete();
        pulse_start();
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL beef_timeout got busy=%b want 0", busy); end
        checks++; if (rx.size() != 44) begin errors++; $display("FAIL beef_len got %0d want 44", rx.size()); end
        if (rx.size() == 44) begin
            checks++; if ({rx[18], rx[17], rx[16], rx[15]} !== 32'hDEADBEEF) begin errors++; $display("FAIL beef_bytes got %h%h%h%h want deadbeef", rx[18], rx[17], rx[16], rx[15]); end
            checks++; if (rx[43] !== 8'h25) begin errors++; $display("FAIL beef_checksum got %h want 25", rx[43]); end
        end
        checks++; if (frame_count !== 8'd2) begin errors++; $display("FAIL beef_count got %0d want 2", frame_count); end
    endtask

    task automatic test_overrun();
        bit to;
        load_ramp();
        build_exp(4'd3);
        predicted_digit = 4'd3;
        rx.delete();
        pulse_start();
        repeat (100) @(negedge clk);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_before got %b want 0", overrun); end
        predicted_digit = 4'd9;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", overrun); end
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL ovr_timeout got busy=%b want 0", busy); end
        checks++; if (rx.size() != 44) begin errors++; $display("FAIL ovr_len got %0d want 44", rx.size()); end
        if (rx.size() == 44) begin
            for (int i = 0; i < 44; i++) begin
                checks++; if (rx[i] !== exp_b[i]) begin errors++; $display("FAIL ovr_byte%0d got %h want %h", i, rx[i], exp_b[i]); end
            end
        end
        repeat (50) @(negedge clk);
        checks++; if (frame_count !== 8'd3 || busy !== 1'b0) begin errors++; $display("FAIL ovr_count got %0d busy=%b want 3 busy=0", frame_count, busy); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    endtask

    task automatic test_disabled();
        int  s0;
        bit  seen;
        enable = 1'b0;
        s0 = sends;
        seen = 1'b0;
        pulse_start();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.tx_req || busy) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL dis_activity got %b want 0", seen); end
        checks++; if (sends != s0) begin errors++; $display("FAIL dis_sends got %0d want %0d", sends, s0); end
        enable = 1'b1;
    endtask

    task automatic test_grant();
        bit to;
        load_ramp();
        build_exp(4'd5);
        predicted_digit = 4'd5;
        bus.tx_gnt = 1'b0;
        rx.delete();
        pulse_start();
        repeat (500) @(negedge clk);
        checks++; if (bus.tx_req !== 1'b1 || rx.size() != 0) begin errors++; $display("FAIL gnt_wait got req=%b bytes=%0d want req=1 bytes=0", bus.tx_req, rx.size()); end
        bus.tx_gnt = 1'b1;
        wait_bytes(11, to);
        checks++; if (to) begin errors++; $display("FAIL gnt_bytes_timeout got %0d want 11", rx.size()); end
        bus.tx_gnt = 1'b0;
        repeat (2000) @(negedge clk);
        checks++; if (rx.size() != 11 || busy !== 1'b1) begin errors++; $display("FAIL gnt_hold got bytes=%0d busy=%b want 11 busy=1", rx.size(), busy); end
        bus.tx_gnt = 1'b1;
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL gnt_timeout got busy=%b want 0", busy); end
        checks++; if (ungranted != 0) begin errors++; $display("FAIL gnt_ungranted_send got %0d want 0", ungranted); end
        checks++; if (rx.size() != 44) begin errors++; $display("FAIL gnt_len got %0d want 44", rx.size()); end
        if (rx.size() == 44) begin
            for (int i = 0; i < 44; i++) begin
                checks++; if (rx[i] !== exp_b[i]) begin errors++; $display("FAIL gnt_byte%0d got %h want %h", i, rx[i], exp_b[i]); end
            end
        end
        checks++; if (frame_count !== 8'd4) begin errors++; $display("FAIL gnt_count got %0d want 4", frame_count); end
    endtask

    task automatic test_reset_mid();
        bit to;
        int s0;
        load_ramp();
        build_exp(4'd2);
        predicted_digit = 4'd2;
        rx.delete();
        pulse_start();
        wait_bytes(20, to);
        checks++; if (to) begin errors++; $display("FAIL rmid_bytes_timeout got %0d want 20", rx.size()); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.tx_req !== 1'b0 || busy !== 1'b0 || bus.tx_send !== 1'b0) begin errors++; $display("FAIL rmid_outputs got req=%b busy=%b send=%b want 0 0 0", bus.tx_req, busy, bus.tx_send); end
        checks++; if (frame_count !== 8'd0 || overrun !== 1'b0) begin errors++; $display("FAIL rmid_status got count=%0d ovr=%b want 0 0", frame_count, overrun); end
        rst = 1'b0;
        s0 = sends;
        repeat (100) @(negedge clk);
        checks++; if (sends != s0) begin errors++; $display("FAIL rmid_send_after_reset got %0d want %0d", sends, s0); end
        rx.delete();
        pulse_start();
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL rmid_timeout got busy=%b want 0", busy); end
        checks++; if (rx.size() != 44) begin errors++; $display("FAIL rmid_len got %0d want 44", rx.size()); end
        if (rx.size() == 44) begin
            for (int i = 0; i < 44; i++) begin
                checks++; if (rx[i] !== exp_b[i]) begin errors++; $display("FAIL rmid_byte%0d got %h want %h", i, rx[i], exp_b[i]); end
            end
        end
        checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL rmid_count got %0d want 1", frame_count); end
    endtask

    initial begin
        bus.tx_gnt = 1'b1;
        for (int i = 0; i < 64; i++) ram[i] = 8'h00;
        test_reset();
        test_frame();
        test_deadbeef();
        test_overrun();
        test_disabled();
        test_grant();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
